fifo_unpack: RTL
================

// Module: fifo_unpack
//
// PURPOSE
//  Width-down serializer: the transmit-side counterpart of the narrow-to-wide collector.
//  Latches one wide word (e.g. the 264-bit PUF response) and emits it as SZ_IN/SZ_OUT
//  narrow chunks, MSB chunk first, over a valid/ack handshake.
//  Feeds a byte-wide sink (UART TX) so a response can be shipped off-chip.
//  A collector with SZ_IN/SZ_OUT swapped rebuilds the identical word on the far end.
//
// PARAMETERS
//  SZ_IN   264  wide input word width (bits); must be an integer multiple of SZ_OUT
//  SZ_OUT  8    output chunk width (bits)
//  COUNT   (localparam) SZ_IN/SZ_OUT = chunks per word; counter width $clog2(COUNT+1)
//
// PORTS
//  clk       in   1       single clock, all logic on posedge
//  rst       in   1       synchronous, active-high reset
//  start     in   1       load request; sampled only in IDLE
//  data_in   in   SZ_IN   wide word, captured on the edge where start is accepted
//  busy      out  1       1 from the cycle after accept until the frame ends
//  data_out  out  SZ_OUT  current chunk, registered
//  valid     out  1       data_out holds a chunk for the sink
//  ack       in   1       sink accepts data_out this cycle (transfer = valid & ack)
//  done      out  1       1-cycle pulse; frame fully transferred
//
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, shift reg=0, counter=0, accumulator=0.
//    Outputs busy=0, valid=0, done=0, data_out=0. Takes priority mid-frame; the
//    partial frame is discarded and resumes nowhere.
//  - States: IDLE, SEND, CHK (CHK exists only with the macro).
//  - IDLE:
//    - start=1 -> shift reg <= data_in, counter <= 0, state <= SEND.
//    - valid=1 and busy=1 next cycle; data_out = data_in[SZ_IN-1 -: SZ_OUT] (1-cycle latency).
//  - SEND, transfer:
//    - Shift reg left by SZ_OUT; data_out <= next chunk; counter++.
//    - Last chunk (counter==COUNT-1) without macro: state <= IDLE, valid <= 0, busy <= 0,
//      done <= 1 for exactly that following cycle.
//  - SEND, valid=1 & ack=0: data_out, counter and state hold unchanged (no drop, no repeat).
//  - Throughput: one chunk per cycle while ack stays high; frame = COUNT transfer cycles.
//  - start outside IDLE: ignored. data_in is don't-care except on the accept edge.
//  - start in the done cycle: accepted, since state is already IDLE.
//  - ack while valid=0: ignored.
//  - done never coincides with valid=1 of the same frame.
//
// CONFIGURATION
//  UNPACK_CHECKSUM_EN
//  - Defined: a SZ_OUT-bit XOR accumulator folds in each transferred data chunk
//    (cleared on accept). After the last data chunk the FSM enters CHK instead of IDLE.
//    CHK presents accumulator ^ final chunk as one extra chunk, valid=1, same hold rules.
//    On that transfer -> IDLE, done pulse. Frame = COUNT+1 chunks.
//  - Undefined: no accumulator, no CHK state; frame = COUNT chunks.
//
// TESTING (SZ_IN=264, SZ_OUT=8 unless noted)
//  1. Word with bytes 0x01..0x21 MSB-first, start 1 cycle, ack=1
//     -> data_out 0x01,0x02..0x21 on 33 consecutive valid cycles, then done=1 for 1 cycle.
//     With UNPACK_CHECKSUM_EN: a 34th chunk 0x01, then done.
//  2. Same word, ack toggles 1/0 each cycle -> each byte held while ack=0,
//     sequence unchanged, 66 cycles of valid.
//  3. start pulsed with data_in=all-ones during byte 10 -> ignored; frame completes
//     with the original bytes, no second frame.
//  4. rst=1 after byte 5 transferred -> next cycle valid=0, busy=0, data_out=0.
//     A new start then emits from byte 0x01.
//  5. Two frames back-to-back, start asserted in the done cycle -> second frame's first
//     byte valid on the next cycle; no byte lost or duplicated.
//  6. SZ_IN=16, SZ_OUT=8, word 0xA55A -> 0xA5, 0x5A, done.
//     With macro: a third chunk 0xFF.

Source files
------------

// File: rtl/fifo_unpack.sv
// Width-down serializer: latches one SZ_IN-bit word and emits SZ_IN/SZ_OUT chunks, MSB first.
// Optional `UNPACK_CHECKSUM_EN appends one XOR checksum chunk to every frame.
module fifo_unpack #(
  parameter int SZ_IN  = 264,
  parameter int SZ_OUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SZ_IN-1:0]  data_in,
  output logic              busy,
  output logic [SZ_OUT-1:0] data_out,
  output logic              valid,
  input  logic              ack,
  output logic              done,
  output logic [1:0]        state_dbg
);

  localparam int COUNT = SZ_IN / SZ_OUT;
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

`ifdef UNPACK_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CHK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t            state, state_nxt;
  logic [SZ_IN-1:0]  shift_reg;
  logic [SZ_IN-1:0]  shift_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              load, xfer, last_xfer;
`ifdef UNPACK_CHECKSUM_EN
  logic [SZ_OUT-1:0] acc;
  logic              chk_xfer;
`endif

  assign state_dbg = state;
  assign shift_nxt = shift_reg << SZ_OUT;

  // Handshake: a chunk moves on every rising edge where valid and ack are both high;
  // while valid is high and ack is low, data_out, counter and state hold.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
`ifdef UNPACK_CHECKSUM_EN
    chk_xfer  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (valid && ack) begin
          xfer = 1'b1;
          if (cnt == LAST_IDX) begin
            last_xfer = 1'b1;
`ifdef UNPACK_CHECKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = IDLE;
`endif
          end
        end
      end
`ifdef UNPACK_CHECKSUM_EN
      CHK: begin
        if (valid && ack) begin
          chk_xfer  = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef UNPACK_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (load) begin
        shift_reg <= data_in;
        data_out  <= data_in[SZ_IN-1 -: SZ_OUT];
        cnt       <= '0;
        valid     <= 1'b1;
        busy      <= 1'b1;
`ifdef UNPACK_CHECKSUM_EN
        acc       <= '0;
`endif
      end else if (xfer) begin
        shift_reg <= shift_nxt;
        cnt       <= cnt + CNT_W'(1);
`ifdef UNPACK_CHECKSUM_EN
        // The checksum chunk is the fold of every data chunk, including the last one.
        acc <= acc ^ data_out;
        if (last_xfer) data_out <= acc ^ data_out;
        else           data_out <= shift_nxt[SZ_IN-1 -: SZ_OUT];
`else
        if (last_xfer) begin
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          data_out <= shift_nxt[SZ_IN-1 -: SZ_OUT];
        end
`endif
      end
`ifdef UNPACK_CHECKSUM_EN
      else if (chk_xfer) begin
        valid <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
`endif
    end
  end

endmodule
